// File: rtl/conv_bram_pkg.sv
// Shared constants and helpers for the ping-pong feature-map store.
package conv_bram_pkg;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_BOTH  = 2'd2;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/conv_fmap_pingpong_bram_bank.sv
// Simple dual-port byte-enable block RAM with a registered 1-cycle read.
module bram_bank_sdp
    import conv_bram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    localparam int BE_W  = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdin,
    input  logic [BE_W-1:0]   wbe,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (wbe[i]) mem[waddr][i*8 +: 8] <= wdin[i*8 +: 8];
            end
        end
        // rdata only moves on a read, so it holds between accepted reads
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/conv_fmap_pingpong_bram.sv
// Double-buffered feature-map store: producer fills one bank while the consumer drains the other.
module conv_fmap_pingpong_bram
    import conv_bram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int BE_W    = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_din,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dout,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              rd_ready,
    output logic [1:0]        full_cnt,
    output logic              wr_err,
    output logic              rd_err
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic              wr_bank, rd_bank;
    logic [1:0]        cnt_q;
    logic              wr_ok, rd_ok, wr_done_ok, rd_done_ok;
    logic [DATA_W-1:0] bank_q [2];
    logic              rd_v1, rd_sel1, rd_seen;
    logic [DATA_W-1:0] rd_data1;

    assign wr_ready   = (cnt_q != CNT_BOTH);
    assign rd_ready   = (cnt_q != CNT_EMPTY);
    assign full_cnt   = cnt_q;
    assign wr_ok      = wr_en & wr_ready & ({1'b0, wr_addr} < DEPTH_X);
    assign rd_ok      = rd_en & rd_ready & ({1'b0, rd_addr} < DEPTH_X);
    assign wr_done_ok = wr_done & wr_ready;
    assign rd_done_ok = rd_done & rd_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bram_bank_sdp #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .we    (wr_ok && (wr_bank == 1'(b))),
            .waddr (wr_addr),
            .wdin  (wr_din),
            .wbe   (wr_be),
            .re    (rd_ok && (rd_bank == 1'(b))),
            .raddr (rd_addr),
            .rdata (bank_q[b])
        );
    end

    // Bank select travels with the read, so rd_done alongside the last read is safe
    assign rd_data1 = rd_seen ? bank_q[rd_sel1] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            cnt_q   <= CNT_EMPTY;
            rd_v1   <= 1'b0;
            rd_sel1 <= 1'b0;
            rd_seen <= 1'b0;
            wr_err  <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            if (wr_done_ok) wr_bank <= ~wr_bank;
            if (rd_done_ok) rd_bank <= ~rd_bank;
            case ({wr_done_ok, rd_done_ok})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            rd_v1 <= rd_ok;
            if (rd_ok) begin
                rd_sel1 <= rd_bank;
                rd_seen <= 1'b1;
            end
            wr_err <= (wr_en & ~wr_ok) | (wr_done & ~wr_ready);
            rd_err <= (rd_en & ~rd_ok) | (rd_done & ~rd_ready);
        end
    end

    if (READ_LAT >= READ_LAT_MAX) begin : g_oreg
        logic              v2;
        logic [DATA_W-1:0] d2;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= rd_v1;
                if (rd_v1) d2 <= rd_data1;
            end
        end
        assign rd_valid = v2;
        assign rd_dout  = d2;
    end else begin : g_noreg
        assign rd_valid = rd_v1;
        assign rd_dout  = rd_data1;
    end

endmodule

// File: tb/tb_conv_fmap_pingpong_bram.sv
// Directed bench: one instance per read latency, driven by identical stimulus.
module tb_conv_fmap_pingpong_bram;

    localparam int DW = 32;
    localparam int DP = 12;
    localparam int AW = $clog2(DP);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, wr_done, rd_en, rd_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_din;
    logic [3:0]    wr_be;

    logic          wr_ready_a, rd_ready_a, rd_valid_a, wr_err_a, rd_err_a;
    logic [DW-1:0] rd_dout_a;
    logic [1:0]    full_cnt_a;
    logic          wr_ready_b, rd_ready_b, rd_valid_b, wr_err_b, rd_err_b;
    logic [DW-1:0] rd_dout_b;
    logic [1:0]    full_cnt_b;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_w [4];

    always #5 clk = ~clk;

    conv_fmap_pingpong_bram #(.DATA_W(DW), .DEPTH(DP), .READ_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
        .wr_be(wr_be), .wr_done(wr_done), .wr_ready(wr_ready_a), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_dout(rd_dout_a), .rd_valid(rd_valid_a), .rd_done(rd_done),
        .rd_ready(rd_ready_a), .full_cnt(full_cnt_a), .wr_err(wr_err_a), .rd_err(rd_err_a)
    );

    conv_fmap_pingpong_bram #(.DATA_W(DW), .DEPTH(DP), .READ_LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
        .wr_be(wr_be), .wr_done(wr_done), .wr_ready(wr_ready_b), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_dout(rd_dout_b), .rd_valid(rd_valid_b), .rd_done(rd_done),
        .rd_ready(rd_ready_b), .full_cnt(full_cnt_b), .wr_err(wr_err_b), .rd_err(rd_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_din = d; wr_be = be;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic pulse_done(input logic w, input logic r);
        wr_done = w; rd_done = r;
        cyc();
        wr_done = 1'b0; rd_done = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] cnt);
        chk({tag, "_cnt_a"}, 32'(full_cnt_a), 32'(cnt));
        chk({tag, "_cnt_b"}, 32'(full_cnt_b), 32'(cnt));
        chk({tag, "_wrdy"}, 32'(wr_ready_a), 32'(cnt != 2'd2));
        chk({tag, "_rrdy"}, 32'(rd_ready_a), 32'(cnt != 2'd0));
    endtask

    // Back-to-back reads of exp_w[0..n-1] starting at a0; checks both latencies
    task automatic read_seq(input string tag, input int n, input logic [AW-1:0] a0);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                rd_en = 1'b1; rd_addr = AW'(a0 + AW'(i));
            end else begin
                rd_en = 1'b0;
            end
            cyc();
            if (i < n) begin
                chk({tag, "_v_a"}, 32'(rd_valid_a), 32'd1);
                chk({tag, "_d_a"}, rd_dout_a, exp_w[i]);
            end else begin
                chk({tag, "_vend_a"}, 32'(rd_valid_a), 32'd0);
            end
            if (i > 0) begin
                chk({tag, "_v_b"}, 32'(rd_valid_b), 32'd1);
                chk({tag, "_d_b"}, rd_dout_b, exp_w[i-1]);
            end else begin
                chk({tag, "_v0_b"}, 32'(rd_valid_b), 32'd0);
            end
        end
        cyc();
        chk({tag, "_vend_b"}, 32'(rd_valid_b), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_din = '0; wr_be = '0;
        @(negedge clk);
        cyc();
        cyc();

        // Reset state
        chk_cnt("rst", 2'd0);
        chk("rst_valid_a", 32'(rd_valid_a), 32'd0);
        chk("rst_valid_b", 32'(rd_valid_b), 32'd0);
        chk("rst_dout_a", rd_dout_a, 32'd0);
        chk("rst_dout_b", rd_dout_b, 32'd0);
        chk("rst_werr", 32'(wr_err_a), 32'd0);
        chk("rst_rerr", 32'(rd_err_a), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Fill bank0 and drain it
        wr(4'd0, 32'h11, 4'hF);
        wr(4'd1, 32'h22, 4'hF);
        wr(4'd2, 32'h33, 4'hF);
        wr(4'd3, 32'h44, 4'hF);
        pulse_done(1'b1, 1'b0);
        chk_cnt("fill0", 2'd1);
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
        read_seq("rd0", 4, 4'd0);
        pulse_done(1'b0, 1'b1);
        chk_cnt("drain0", 2'd0);

        // Byte enables into bank1
        wr(4'd5, 32'hAABBCCDD, 4'hF);
        wr(4'd5, 32'h00000011, 4'b0001);
        pulse_done(1'b1, 1'b0);
        exp_w[0] = 32'hAABBCC11;
        read_seq("be", 1, 4'd5);
        pulse_done(1'b0, 1'b1);
        chk_cnt("drain1", 2'd0);

        // Both banks full
        wr(4'd0, 32'hA0A0A0A0, 4'hF);
        wr(4'd1, 32'hA1A1A1A1, 4'hF);
        pulse_done(1'b1, 1'b0);
        wr(4'd0, 32'hB0B0B0B0, 4'hF);
        wr(4'd1, 32'hB1B1B1B1, 4'hF);
        pulse_done(1'b1, 1'b0);
        chk_cnt("full2", 2'd2);
        wr(4'd0, 32'hDEADBEEF, 4'hF);
        chk("full_werr", 32'(wr_err_a), 32'd1);
        cyc();
        chk("full_werr_clr", 32'(wr_err_a), 32'd0);
        pulse_done(1'b1, 1'b0);
        chk("full_done_werr", 32'(wr_err_b), 32'd1);
        chk_cnt("full_done", 2'd2);
        exp_w[0] = 32'hA0A0A0A0; exp_w[1] = 32'hA1A1A1A1;
        read_seq("full_rd", 2, 4'd0);
        pulse_done(1'b0, 1'b1);
        chk_cnt("rel0", 2'd1);

        // Simultaneous hand-over: refill bank0 while bank1 is released
        wr(4'd0, 32'hC0C0C0C0, 4'hF);
        wr(4'd1, 32'hC1C1C1C1, 4'hF);
        pulse_done(1'b1, 1'b1);
        chk_cnt("simul", 2'd1);
        exp_w[0] = 32'hC0C0C0C0; exp_w[1] = 32'hC1C1C1C1;
        read_seq("simul_rd", 2, 4'd0);
        pulse_done(1'b0, 1'b1);
        chk_cnt("simul_rel", 2'd0);

        // Protocol errors with no full bank
        rd_en = 1'b1; rd_addr = 4'd0;
        cyc();
        rd_en = 1'b0;
        chk("empty_rerr", 32'(rd_err_a), 32'd1);
        chk("empty_rvalid_a", 32'(rd_valid_a), 32'd0);
        chk("empty_hold_a", rd_dout_a, 32'hC1C1C1C1);
        cyc();
        chk("empty_rvalid_b", 32'(rd_valid_b), 32'd0);
        chk("empty_hold_b", rd_dout_b, 32'hC1C1C1C1);
        chk("empty_rerr_clr", 32'(rd_err_a), 32'd0);
        pulse_done(1'b0, 1'b1);
        chk("empty_done_rerr", 32'(rd_err_b), 32'd1);
        chk_cnt("empty_done", 2'd0);

        // Address boundaries: last word accepted, DEPTH rejected
        wr(4'd12, 32'h0BADF00D, 4'hF);
        chk("oor_werr", 32'(wr_err_a), 32'd1);
        wr(4'd11, 32'h12345678, 4'hF);
        chk("last_werr", 32'(wr_err_a), 32'd0);
        pulse_done(1'b1, 1'b0);
        exp_w[0] = 32'h12345678;
        read_seq("last_rd", 1, 4'd11);
        rd_en = 1'b1; rd_addr = 4'd12;
        cyc();
        rd_en = 1'b0;
        chk("oor_rerr", 32'(rd_err_a), 32'd1);
        chk("oor_rvalid_a", 32'(rd_valid_a), 32'd0);
        cyc();
        chk("oor_rvalid_b", 32'(rd_valid_b), 32'd0);

        // Reset with two reads in flight on the 2-cycle instance
        rd_en = 1'b1; rd_addr = 4'd11;
        cyc();
        chk("fly_v_a", 32'(rd_valid_a), 32'd1);
        cyc();
        chk("fly_v_b", 32'(rd_valid_b), 32'd1);
        rd_en = 1'b0; rst_n = 1'b0;
        cyc();
        chk("mrst_v_b", 32'(rd_valid_b), 32'd0);
        chk("mrst_d_b", rd_dout_b, 32'd0);
        chk_cnt("mrst", 2'd0);
        rst_n = 1'b1;
        cyc();
        chk("mrst_stale_b", 32'(rd_valid_b), 32'd0);
        chk("mrst_stale_a", 32'(rd_valid_a), 32'd0);
        cyc();
        chk("mrst_stale2_b", 32'(rd_valid_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
